// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions for the hex encoder and the scan decoder.
// Segment vectors are active-low, bit0 = a .. bit6 = g, so a lit segment
// reads as 0 and an all-off digit reads as 7'h7F.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_HEX_0 = 7'h40;
  localparam seg_t SEG_HEX_1 = 7'h79;
  localparam seg_t SEG_HEX_2 = 7'h24;
  localparam seg_t SEG_HEX_3 = 7'h30;
  localparam seg_t SEG_HEX_4 = 7'h19;
  localparam seg_t SEG_HEX_5 = 7'h12;
  localparam seg_t SEG_HEX_6 = 7'h02;
  localparam seg_t SEG_HEX_7 = 7'h78;
  localparam seg_t SEG_HEX_8 = 7'h00;
  localparam seg_t SEG_HEX_9 = 7'h10;
  localparam seg_t SEG_HEX_A = 7'h08;
  localparam seg_t SEG_HEX_B = 7'h03;
  localparam seg_t SEG_HEX_C = 7'h46;
  localparam seg_t SEG_HEX_D = 7'h21;
  localparam seg_t SEG_HEX_E = 7'h06;
  localparam seg_t SEG_HEX_F = 7'h0E;

  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_segment_scan_decoder_if.sv
// Bus bundle between a multiplexed 7-segment display and the scan decoder.
// Optional macro SEVEN_SEG_DP_EN adds the decimal point line DP and the
// per-digit captured decimal point DP_OUT.
//   SEG[6:0]      active-low segment lines (display -> decoder)
//   AN[N-1:0]     active-low anode enables (display -> decoder)
//   ERR_CLR       clear sticky error flags (checker -> decoder)
//   DIGITS        decoded nibbles, digit i at [4i+3:4i] (decoder -> checker)
//   DIGIT_VALID   digit holds a legal hex value
//   BLANK         digit last seen all-off
//   FRAME_DONE    one-cycle pulse when every digit was captured
//   ERR_SEG/ERR_AN sticky error flags
// Signalling: there is no valid/ready handshake. The display side drives
// SEG/AN as free-running levels, and every decoder output is a registered
// level that the consumer may sample on any cycle; FRAME_DONE is the only
// pulse and is asserted for exactly one cycle per completed frame.
interface seven_segment_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_pkg::*;

  seg_t                    SEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    ERR_CLR;
  logic [4*NUM_DIGITS-1:0] DIGITS;
  logic [NUM_DIGITS-1:0]   DIGIT_VALID;
  logic [NUM_DIGITS-1:0]   BLANK;
  logic                    FRAME_DONE;
  logic                    ERR_SEG;
  logic                    ERR_AN;
`ifdef SEVEN_SEG_DP_EN
  logic                    DP;
  logic [NUM_DIGITS-1:0]   DP_OUT;

  modport master (output SEG, AN, ERR_CLR, DP,
                  input  DIGITS, DIGIT_VALID, BLANK, FRAME_DONE, ERR_SEG, ERR_AN, DP_OUT);
  modport slave  (input  SEG, AN, ERR_CLR, DP,
                  output DIGITS, DIGIT_VALID, BLANK, FRAME_DONE, ERR_SEG, ERR_AN, DP_OUT);
`else
  modport master (output SEG, AN, ERR_CLR,
                  input  DIGITS, DIGIT_VALID, BLANK, FRAME_DONE, ERR_SEG, ERR_AN);
  modport slave  (input  SEG, AN, ERR_CLR,
                  output DIGITS, DIGIT_VALID, BLANK, FRAME_DONE, ERR_SEG, ERR_AN);
`endif

endinterface

// File: rtl/seg_pattern_decode.sv
// Inverse of the hex-to-segment encoder, purely combinational.
//   seg       active-low segment vector
//   is_hex    seg is one of the 16 hex glyphs
//   is_blank  seg is all segments off
//   nibble    hex value of the glyph (0 when not hex)
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  seg_t       seg,
  output logic       is_hex,
  output logic       is_blank,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex   = 1'b1;
    is_blank = 1'b0;
    nibble   = 4'h0;
    case (seg)
      SEG_HEX_0: nibble = 4'h0;
      SEG_HEX_1: nibble = 4'h1;
      SEG_HEX_2: nibble = 4'h2;
      SEG_HEX_3: nibble = 4'h3;
      SEG_HEX_4: nibble = 4'h4;
      SEG_HEX_5: nibble = 4'h5;
      SEG_HEX_6: nibble = 4'h6;
      SEG_HEX_7: nibble = 4'h7;
      SEG_HEX_8: nibble = 4'h8;
      SEG_HEX_9: nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      SEG_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Snoops a time-multiplexed active-low 7-segment bus and rebuilds the hex
// value shown on each digit. SEG/AN are double-synchronized; a digit is
// captured once per window in which the synchronized bus holds still for
// STABLE_CYCLES cycles, landing on the outputs STABLE_CYCLES+2 edges after
// the bus changed.
// Optional macro SEVEN_SEG_DP_EN: adds DP input and DP_OUT per digit.
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    slave side of seven_segment_scan_decoder_if
module seven_segment_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  seven_segment_scan_decoder_if.slave bus
);

`ifdef SEVEN_SEG_DP_EN
  localparam int BW = NUM_DIGITS + 8;
`else
  localparam int BW = NUM_DIGITS + 7;
`endif
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  // Capture is registered on the edge where the counter becomes
  // STABLE_CYCLES-1, i.e. while it still reads STABLE_CYCLES-2.
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

  logic [BW-1:0] bus_raw, sync_1, sync_2, sync_prev;
  logic [7:0]    stable_cnt;

`ifdef SEVEN_SEG_DP_EN
  assign bus_raw = {bus.DP, bus.AN, bus.SEG};
`else
  assign bus_raw = {bus.AN, bus.SEG};
`endif

  // The idle bus (all anodes off, all segments off, DP off) is all ones, so
  // clearing the pipeline to ones makes reset look like an ordinary idle
  // bus instead of a burst of "every anode low" that would flag ERR_AN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_1     <= '1;
      sync_2     <= '1;
      sync_prev  <= '1;
      stable_cnt <= '0;
    end else begin
      sync_1    <= bus_raw;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      if (sync_2 != sync_prev)
        stable_cnt <= '0;
      else if (stable_cnt < CNT_MAX)
        stable_cnt <= stable_cnt + 8'd1;
    end
  end

  seg_t                  seg_s;
  logic [NUM_DIGITS-1:0] an_low;
  logic                  capture, single_an, multi_an;
  logic                  is_hex, is_blank;
  logic [3:0]            nibble;

  assign seg_s     = sync_2[6:0];
  assign an_low    = ~sync_2[NUM_DIGITS+6:7];
  assign capture   = (sync_2 == sync_prev) && (stable_cnt == CNT_CAP);
  assign single_an = $onehot(an_low);
  assign multi_an  = (an_low != '0) && !single_an;

  seg_pattern_decode u_decode (
    .seg      (seg_s),
    .is_hex   (is_hex),
    .is_blank (is_blank),
    .nibble   (nibble)
  );

  logic [4*NUM_DIGITS-1:0] digits_q, digits_n;
  logic [NUM_DIGITS-1:0]   valid_q, valid_n, blank_q, blank_n;
  logic [NUM_DIGITS-1:0]   seen_q, seen_n, seen_set;
  logic                    frame_q, frame_n;
  logic                    err_seg_q, err_seg_n, err_an_q, err_an_n;
`ifdef SEVEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q, dp_n;
`endif

  always_comb begin
    digits_n  = digits_q;
    valid_n   = valid_q;
    blank_n   = blank_q;
    seen_n    = seen_q;
    seen_set  = seen_q | an_low;
    frame_n   = 1'b0;
    // A new error on the same cycle as ERR_CLR overrides the clear below.
    err_seg_n = err_seg_q & ~bus.ERR_CLR;
    err_an_n  = err_an_q & ~bus.ERR_CLR;
`ifdef SEVEN_SEG_DP_EN
    dp_n      = dp_q;
`endif
    if (capture && single_an) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (an_low[i] && is_hex) digits_n[4*i +: 4] = nibble;
      valid_n = (valid_q & ~an_low) | ({NUM_DIGITS{is_hex}} & an_low);
      blank_n = (blank_q & ~an_low) | ({NUM_DIGITS{is_blank}} & an_low);
`ifdef SEVEN_SEG_DP_EN
      dp_n    = (dp_q & ~an_low) | ({NUM_DIGITS{~sync_2[BW-1]}} & an_low);
`endif
      if (!is_hex && !is_blank) err_seg_n = 1'b1;
      // Completing capture starts the next frame's mask.
      if (&seen_set) begin
        frame_n = 1'b1;
        seen_n  = an_low;
      end else begin
        seen_n  = seen_set;
      end
    end
    if (capture && multi_an) err_an_n = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digits_q  <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      err_seg_q <= 1'b0;
      err_an_q  <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
      dp_q      <= '0;
`endif
    end else begin
      digits_q  <= digits_n;
      valid_q   <= valid_n;
      blank_q   <= blank_n;
      seen_q    <= seen_n;
      frame_q   <= frame_n;
      err_seg_q <= err_seg_n;
      err_an_q  <= err_an_n;
`ifdef SEVEN_SEG_DP_EN
      dp_q      <= dp_n;
`endif
    end
  end

  assign bus.DIGITS      = digits_q;
  assign bus.DIGIT_VALID = valid_q;
  assign bus.BLANK       = blank_q;
  assign bus.FRAME_DONE  = frame_q;
  assign bus.ERR_SEG     = err_seg_q;
  assign bus.ERR_AN      = err_an_q;
`ifdef SEVEN_SEG_DP_EN
  assign bus.DP_OUT      = dp_q;
`endif

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed scenarios plus a random
// scan, all checked every cycle against a sample-history reference model.
module tb_seven_segment_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEVEN_SEG_DP_EN
  localparam int BW = ND + 8;
`else
  localparam int BW = ND + 7;
`endif

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  seven_segment_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Glyph table written out independently of the design package.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // hist[k] is the bus value sampled k rising edges ago (hist[0] = this edge).
  // A capture lands on the edge where the samples taken 2..SC+1 edges ago are
  // identical and the one before that run is different.
  logic [BW-1:0] hist [$];
  logic [3:0]    m_digit [ND];
  logic [ND-1:0] m_valid, m_blank, m_seen, m_dp;
  logic          m_frame, m_err_seg, m_err_an;

  function automatic logic [BW-1:0] sample_bus();
`ifdef SEVEN_SEG_DP_EN
    return {bus.DP, bus.AN, bus.SEG};
`else
    return {bus.AN, bus.SEG};
`endif
  endfunction

  function automatic logic [4*ND-1:0] m_digits_flat();
    logic [4*ND-1:0] f;
    for (int i = 0; i < ND; i++) f[4*i +: 4] = m_digit[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_digit[i] = 4'h0;
    m_valid = '0; m_blank = '0; m_seen = '0; m_dp = '0;
    m_frame = 1'b0; m_err_seg = 1'b0; m_err_an = 1'b0;
    hist.delete();
    for (int k = 0; k < SC + 3; k++) hist.push_front('1);
  endtask

  task automatic model_step();
    logic [BW-1:0] p;
    logic [6:0]    seg;
    logic          win;
    int            zeros, idx, found;
    hist.push_front(sample_bus());
    void'(hist.pop_back());
    m_frame   = 1'b0;
    m_err_seg = m_err_seg & !bus.ERR_CLR;
    m_err_an  = m_err_an & !bus.ERR_CLR;
    win = 1'b1;
    for (int k = 3; k <= SC + 1; k++) if (hist[k] != hist[2]) win = 1'b0;
    if (hist[SC+2] == hist[2]) win = 1'b0;
    if (win) begin
      p = hist[2];
      seg = p[6:0];
      zeros = 0; idx = 0;
      for (int k = 0; k < ND; k++) if (!p[7+k]) begin zeros++; idx = k; end
      if (zeros == 1) begin
        found = -1;
        for (int v = 0; v < 16; v++) if (hex_tab[v] == seg) found = v;
        if (found >= 0) begin
          m_digit[idx] = 4'(found); m_valid[idx] = 1'b1; m_blank[idx] = 1'b0;
        end else if (seg == 7'h7F) begin
          m_valid[idx] = 1'b0; m_blank[idx] = 1'b1;
        end else begin
          m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; m_err_seg = 1'b1;
        end
        m_dp[idx] = ~p[BW-1];
        m_seen[idx] = 1'b1;
        if (&m_seen) begin
          m_frame = 1'b1;
          m_seen = '0;
          m_seen[idx] = 1'b1;
        end
      end else if (zeros > 1) begin
        m_err_an = 1'b1;
      end
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) model_reset();
    else        model_step();
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge CLK) begin
    check("digits",      bus.DIGITS,      m_digits_flat());
    check("digit_valid", bus.DIGIT_VALID, m_valid);
    check("blank",       bus.BLANK,       m_blank);
    check("frame_done",  bus.FRAME_DONE,  m_frame);
    check("err_seg",     bus.ERR_SEG,     m_err_seg);
    check("err_an",      bus.ERR_AN,      m_err_an);
`ifdef SEVEN_SEG_DP_EN
    check("dp_out",      bus.DP_OUT,      m_dp);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    bus.AN  = an;
    bus.SEG = seg;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_err_clr();
    bus.ERR_CLR = 1'b1;
    @(negedge CLK);
    bus.ERR_CLR = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, bus.DIGITS, '0);
    check({tag, "_valid"},  bus.DIGIT_VALID, '0);
    check({tag, "_blank"},  bus.BLANK, '0);
    check({tag, "_frame"},  bus.FRAME_DONE, '0);
    check({tag, "_errseg"}, bus.ERR_SEG, '0);
    check({tag, "_erran"},  bus.ERR_AN, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [ND-1:0] r_an;
  logic [6:0]    r_seg;
  int            r_kind, r_len, r_gap;
  logic          r_clr_en;

  initial begin
    bus.SEG = 7'h7F;
    bus.AN = '1;
    bus.ERR_CLR = 1'b0;
`ifdef SEVEN_SEG_DP_EN
    bus.DP = 1'b1;
`endif
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // 1: reset state, then idle
    check_all_zero("reset");
    repeat (20) @(negedge CLK);
    check_all_zero("idle");

    // 2: scan digits 0..3 showing 1,2,3,F
    drive(4'hE, 7'h79, 10); drive(4'hF, 7'h7F, 2);
    drive(4'hD, 7'h24, 10); drive(4'hF, 7'h7F, 2);
    drive(4'hB, 7'h30, 10); drive(4'hF, 7'h7F, 2);
    bus.AN = 4'h7; bus.SEG = 7'h0E;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      check($sformatf("frame_edge%0d", k), bus.FRAME_DONE, (k == SC + 2) ? 1 : 0);
    end
    @(negedge CLK);
    check("scan_digits", bus.DIGITS, 16'hF321);
    check("scan_valid",  bus.DIGIT_VALID, 4'hF);
    drive(4'hF, 7'h7F, 2);

    // 3: too-short window, no capture
    drive(4'hE, 7'h24, 3);
    drive(4'hF, 7'h7F, 8);
    check("short_digits", bus.DIGITS, 16'hF321);
    check("short_valid",  bus.DIGIT_VALID, 4'hF);

    // 4: blank then illegal pattern on digit 0, then clear
    drive(4'hE, 7'h7F, 10);
    check("blank0_blank", bus.BLANK, 4'h1);
    check("blank0_valid", bus.DIGIT_VALID, 4'hE);
    drive(4'hE, 7'h55, 10);
    check("illegal_errseg", bus.ERR_SEG, 1);
    check("illegal_valid",  bus.DIGIT_VALID, 4'hE);
    check("illegal_blank",  bus.BLANK, 4'h0);
    check("illegal_digits", bus.DIGITS, 16'hF321);
    pulse_err_clr();
    check("errseg_cleared", bus.ERR_SEG, 0);
    drive(4'hF, 7'h7F, 4);

    // 5: two anodes low; then clear colliding with a fresh error
    drive(4'hC, 7'h40, 10);
    check("multi_erran",  bus.ERR_AN, 1);
    check("multi_digits", bus.DIGITS, 16'hF321);
    drive(4'hF, 7'h7F, 4);
    pulse_err_clr();
    check("erran_cleared", bus.ERR_AN, 0);
    bus.AN = 4'hC; bus.SEG = 7'h40;
    repeat (SC + 1) @(negedge CLK);
    pulse_err_clr();
    check("erran_clr_collision", bus.ERR_AN, 1);
    drive(4'hF, 7'h7F, 4);

    // 6: reset in the middle of a stable window
    bus.AN = 4'hE; bus.SEG = 7'h40;
    repeat (5) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (SC + 4) @(negedge CLK);
    check("postreset_digit0", bus.DIGITS[3:0], 4'h0);
    check("postreset_valid",  bus.DIGIT_VALID, 4'h1);
    drive(4'hF, 7'h7F, 3);

    // random scan traffic
    repeat (300) begin
      r_kind = $urandom_range(0, 9);
      r_len  = $urandom_range(1, 12);
      r_an   = '1;
      r_an[$urandom_range(0, ND - 1)] = 1'b0;
      r_seg  = hex_tab[$urandom_range(0, 15)];
      if (r_kind == 7) r_seg = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'($urandom_range(0, 127));
      if (r_kind == 8) r_an = ND'($urandom_range(0, (1 << ND) - 1));
      if (r_kind == 9) begin r_an = '1; r_seg = 7'($urandom_range(0, 127)); end
`ifdef SEVEN_SEG_DP_EN
      bus.DP = 1'($urandom_range(0, 1));
`endif
      r_clr_en = ($urandom_range(0, 5) == 0);
      bus.AN = r_an; bus.SEG = r_seg;
      for (int c = 0; c < r_len; c++) begin
        bus.ERR_CLR = r_clr_en && ($urandom_range(0, 3) == 0);
        @(negedge CLK);
      end
      bus.ERR_CLR = 1'b0;
      r_gap = $urandom_range(0, 3);
      if (r_gap > 0) drive(4'hF, 7'h7F, r_gap);
    end
    drive(4'hF, 7'h7F, SC + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-segment encoder.
- Snoops a time-multiplexed, active-low 7-segment bus (segment lines plus per-digit anode enables) and reconstructs the hex value currently shown on each digit.
- Used for display self-check and loopback verification, and for capturing values from an external board that drives a common-anode display.
- Sits next to the display driver on the same clock; its outputs go to the checker/status logic.

Parameters:
NUM_DIGITS, 4, number of anode lines and digits reconstructed (1..8)
STABLE_CYCLES, 4, consecutive cycles the synchronized SEG/AN must hold before a capture (2..255)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
SEG  input  7  segment lines, active-low, bit0=a .. bit6=g
AN  input  NUM_DIGITS  anode enables, active-low, bit i = digit i
ERR_CLR  input  1  synchronous clear of sticky error flags
DIGITS  output  4*NUM_DIGITS  decoded hex nibble per digit, digit i at [4i+3:4i]
DIGIT_VALID  output  NUM_DIGITS  digit i holds a legal hex value
BLANK  output  NUM_DIGITS  digit i last seen as all-segments-off (7'h7F)
FRAME_DONE  output  1  one-cycle pulse once every digit has been captured since the previous pulse
ERR_SEG  output  1  sticky: an enabled digit showed a pattern that is neither hex nor blank
ERR_AN  output  1  sticky: more than one anode was low during a stable window

Behaviour:
- Reset (async assert, sync release): DIGITS=0, DIGIT_VALID=0, BLANK=0, FRAME_DONE=0, ERR_SEG=0, ERR_AN=0. Synchronizers, stability counter and seen-mask are also cleared.
- Input sync: SEG and AN each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Stability counter (8 bit):
  - Clears to 0 when the synchronized {AN,SEG} differs from its previous-cycle value.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture fires exactly once per stable window, on the cycle the counter reaches STABLE_CYCLES-1. Capture-to-output latency from an input change is STABLE_CYCLES+2 edges.
- Capture action, by anode state:
  - Exactly one AN bit i low: decode SEG using the inverse encoder table.
    - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
    - Legal hex: DIGITS[i]=value, DIGIT_VALID[i]=1, BLANK[i]=0.
    - 7F: BLANK[i]=1, DIGIT_VALID[i]=0, DIGITS[i] unchanged.
    - Any other pattern: ERR_SEG=1, DIGIT_VALID[i]=0, BLANK[i]=0, DIGITS[i] unchanged.
    - In all three cases, seen-mask bit i is set.
  - All AN high (blanking interval between digits): no capture, no error.
  - Two or more AN low: no capture, ERR_AN=1.
- Frame tracking:
  - When the seen-mask becomes all ones, FRAME_DONE pulses high for one cycle.
  - The mask clears on that same edge, except the bit being set by a capture on that edge, which is retained.
  - Re-capturing a digit before the frame completes only refreshes that digit's outputs.
- Error flags:
  - ERR_SEG and ERR_AN hold until ERR_CLR or reset.
  - If ERR_CLR and a new error occur on the same cycle, the error wins and the flag stays 1.
- No flow control: outputs are registered levels; consumers sample whenever they need.

Optional Feature:
SEVEN_SEG_DP_EN
- Defined:
  - Adds input DP (1 bit, active-low decimal point) and output DP_OUT (NUM_DIGITS bits).
  - DP joins the synchronizer and the stability compare.
  - On any single-anode capture, DP_OUT[i] = ~DP_sync. Reset value 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package seven_seg_pkg:
  - 16 segment-pattern localparams (SEG_HEX_0..SEG_HEX_F).
  - SEG_BLANK = 7'h7F.
  - A typedef for the 7-bit segment vector.
  - Shared with the encoder so both ends use one table.
- Sub-module seg_pattern_decode: purely combinational, SEG(7) -> {is_hex, is_blank, nibble[3:0]}.

Test Plan:
1. Reset with SEG=7F, AN=F -> all outputs 0. No change after 20 idle cycles.
2. Scan digits 0..3 with AN=E,D,B,7 and SEG=79,24,30,0E, 10 cycles each with a 2-cycle all-high gap between digits:
   - DIGITS=16'hF321, DIGIT_VALID=4'hF.
   - FRAME_DONE pulses once, STABLE_CYCLES+2 edges after the digit-3 inputs are applied.
3. AN=E, SEG held for only 3 cycles (< STABLE_CYCLES+0 stable after sync) -> no capture; DIGITS and seen-mask unchanged.
4. AN=E with SEG=7F, then SEG=55 for 10 cycles each:
   - After 7F: BLANK[0]=1.
   - After 55: ERR_SEG=1, DIGIT_VALID[0]=0, BLANK[0]=0.
   - Pulse ERR_CLR -> ERR_SEG=0.
5. AN=C (two digits low) for 10 cycles -> ERR_AN=1, no digit updated. ERR_CLR and a new AN=C error on the same cycle -> ERR_AN stays 1.
6. Assert RST_N low mid-window (counter=2, AN=E, SEG=40) -> outputs clear immediately. After release, inputs held steady -> capture DIGITS[3:0]=0, DIGIT_VALID[0]=1.
